// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, ALU/result-select codes and immediate formats.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_U
  } imm_type_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    result_src_e result_src;
    alu_ctrl_e   alu_ctrl;
  } ctrl_t;

  function automatic logic [XLEN-1:0] imm_extend(input logic [31:0] instr,
                                                 input imm_type_e   kind);
    logic [XLEN-1:0] imm;
    case (kind)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational reads with write-through, one posedge write, x0 hardwired.
module register_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      a1,
  input  logic [4:0]      a2,
  input  logic [4:0]      a3,
  input  logic            we3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs [32];
  logic            wr_en;

  assign wr_en = we3 && (a3 != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '{default: '0};
    end else if (wr_en) begin
      regs[a3] <= wd3;
    end
  end

  // Bypass lets decode see a writeback landing on the same edge it captures on.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (a1 != '0) rd1 = (wr_en && a3 == a1) ? wd3 : regs[a1];
    if (a2 != '0) rd2 = (wr_en && a3 == a2) ? wd3 : regs[a2];
  end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate generation and ID/EX register.
module decode_cycle
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCNextD,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic            ALUSrcE,
  output logic [1:0]      ResultSrcE,
  output logic [2:0]      ALUControlE,
  output logic [2:0]      Funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCNextE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rd;
  logic            is_r;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;

  ctrl_t           ctrl_d;
  imm_type_e       imm_type;
  logic            zero_rs1;
  logic            op_valid;
  alu_ctrl_e       alu_sel;
  logic            alu_ok;

  ctrl_t           ctrl_e;

  assign opcode = InstrD[6:0];
  assign rd     = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];
  assign is_r   = (opcode == OP_R);

  register_file u_register_file (
    .clk (clk),
    .rst (rst),
    .a1  (Rs1D),
    .a2  (Rs2D),
    .a3  (RdW),
    .we3 (RegWriteW),
    .wd3 (ResultW),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2)
  );

  always_comb begin
    alu_ok  = 1'b1;
    alu_sel = ALU_ADD;
    case (funct3)
      3'b000:  alu_sel = (is_r && InstrD[30]) ? ALU_SUB : ALU_ADD;
      3'b100:  alu_sel = ALU_XOR;
      3'b110:  alu_sel = ALU_OR;
      3'b111:  alu_sel = ALU_AND;
      3'b010:  alu_sel = ALU_SLT;
      default: alu_ok  = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_d   = '0;
    imm_type = IMM_I;
    zero_rs1 = 1'b0;
    op_valid = 1'b1;
    case (opcode)
      OP_R: begin
        op_valid         = alu_ok;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_ctrl  = alu_sel;
      end
      OP_I: begin
        op_valid         = alu_ok;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = alu_sel;
      end
      OP_LOAD: begin
        op_valid          = (funct3 == 3'b010);
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
      end
      OP_STORE: begin
        op_valid         = (funct3 == 3'b010);
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_S;
      end
      OP_BRANCH: begin
        op_valid        = (funct3 == 3'b000) || (funct3 == 3'b001);
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_ctrl = ALU_SUB;
        imm_type        = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.jump       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_type          = IMM_J;
      end
      OP_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_U;
        zero_rs1         = 1'b1;
      end
      default: op_valid = 1'b0;
    endcase
    if (!op_valid) ctrl_d = '0;
    if (rd == '0) ctrl_d.reg_write = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      ctrl_e  <= '0;
      Funct3E <= '0;
      RD1E    <= '0;
      RD2E    <= '0;
      ImmExtE <= '0;
      PCE     <= '0;
      PCNextE <= '0;
      RdE     <= '0;
      Rs1E    <= '0;
      Rs2E    <= '0;
    end else begin
      ctrl_e  <= ctrl_d;
      Funct3E <= funct3;
      RD1E    <= zero_rs1 ? '0 : rf_rd1;
      RD2E    <= rf_rd2;
      ImmExtE <= imm_extend(InstrD, imm_type);
      PCE     <= PCD;
      PCNextE <= PCNextD;
      RdE     <= rd;
      Rs1E    <= Rs1D;
      Rs2E    <= Rs2D;
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign ALUSrcE     = ctrl_e.alu_src;
  assign ResultSrcE  = ctrl_e.result_src;
  assign ALUControlE = ctrl_e.alu_ctrl;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed self-checking bench for decode_cycle with hand-computed expectations.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCNextD, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RdW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE, Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCNextE;

  int unsigned tests  = 0;
  int unsigned errors = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCNextD(PCNextD),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCNextE(PCNextE), .RdE(RdE), .Rs1E(Rs1E),
    .Rs2E(Rs2E)
  );

  always #5 clk = ~clk;

  // {RegWrite, MemWrite, Jump, Branch, ALUSrc, ResultSrc[1:0], ALUControl[2:0]}
  logic [9:0] ctrl;
  assign ctrl = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {22'b0, ctrl}, 32'h0);
    check({tag, "_f3"},   {29'b0, Funct3E}, 32'h0);
    check({tag, "_rd1"},  RD1E, 32'h0);
    check({tag, "_rd2"},  RD2E, 32'h0);
    check({tag, "_imm"},  ImmExtE, 32'h0);
    check({tag, "_pc"},   PCE | PCNextE, 32'h0);
    check({tag, "_idx"},  {17'b0, RdE, Rs1E, Rs2E}, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic flush,
                       input logic we, input logic [4:0] rdw, input logic [31:0] res);
    InstrD    = instr;
    FlushE    = flush;
    RegWriteW = we;
    RdW       = rdw;
    ResultW   = res;
  endtask

  initial begin
    rst = 1'b1;
    PCD = 32'h0;
    PCNextD = 32'h4;
    drive(32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    check_zero("reset");

    rst = 1'b0;
    PCD = 32'h10; PCNextD = 32'h14;
    drive(32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0);   // addi x1,x0,5
    tick();
    check("addi_ctrl", {22'b0, ctrl}, {22'b0, 10'b1_0_0_0_1_00_000});
    check("addi_imm", ImmExtE, 32'd5);
    check("addi_rd", {27'b0, RdE}, 32'd1);
    check("addi_pc", PCE, 32'h10);
    check("addi_pcn", PCNextE, 32'h14);

    drive(32'h003100B3, 1'b0, 1'b1, 5'd3, 32'hDEADBEEF);   // add x1,x2,x3
    #1;
    check("rs1d", {27'b0, Rs1D}, 32'd2);
    check("rs2d", {27'b0, Rs2D}, 32'd3);
    tick();
    check("bypass_rd2", RD2E, 32'hDEADBEEF);
    check("bypass_rd1", RD1E, 32'h0);
    check("add_ctrl", {22'b0, ctrl}, {22'b0, 10'b1_0_0_0_0_00_000});
    drive(32'h003100B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("array_rd2", RD2E, 32'hDEADBEEF);

    drive(32'hFE000EE3, 1'b0, 1'b0, 5'd0, 32'h0);   // beq x0,x0,-4
    tick();
    check("beq_ctrl", {22'b0, ctrl}, {22'b0, 10'b0_0_0_1_0_00_001});
    check("beq_imm", ImmExtE, 32'hFFFFFFFC);
    check("beq_f3", {29'b0, Funct3E}, 32'h0);

    PCD = 32'h100; PCNextD = 32'h104;
    drive(32'h00000033, 1'b1, 1'b1, 5'd4, 32'h55);  // flush + writeback x4
    tick();
    check_zero("flush");
    drive(32'h00000033, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("nop_ctrl", {22'b0, ctrl}, 32'h0);
    check("nop_pc", PCE, 32'h100);
    drive(32'h000200B3, 1'b0, 1'b0, 5'd0, 32'h0);   // add x1,x4,x0
    tick();
    check("flush_write_x4", RD1E, 32'h55);

    drive(32'h000000B3, 1'b0, 1'b1, 5'd0, 32'h1234); // write x0, read x0
    tick();
    check("x0_same", RD1E, 32'h0);
    drive(32'h000000B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("x0_later", RD1E, 32'h0);

    drive(32'h0020A423, 1'b0, 1'b1, 5'd8, 32'hAAAA); // sw x2,8(x1), load x8
    tick();
    check("sw_ctrl", {22'b0, ctrl}, {22'b0, 10'b0_1_0_0_1_00_000});
    check("sw_imm", ImmExtE, 32'd8);
    drive(32'hFE20AC23, 1'b0, 1'b0, 5'd0, 32'h0);   // sw x2,-8(x1)
    tick();
    check("sw_neg_imm", ImmExtE, 32'hFFFFFFF8);
    drive(32'h123452B7, 1'b0, 1'b0, 5'd0, 32'h0);   // lui x5,0x12345 (rs1 field = x8)
    tick();
    check("lui_ctrl", {22'b0, ctrl}, {22'b0, 10'b1_0_0_0_1_00_000});
    check("lui_imm", ImmExtE, 32'h12345000);
    check("lui_rd1", RD1E, 32'h0);
    drive(32'h0040A303, 1'b0, 1'b0, 5'd0, 32'h0);   // lw x6,4(x1)
    tick();
    check("lw_ctrl", {22'b0, ctrl}, {22'b0, 10'b1_0_0_0_1_01_000});
    check("lw_imm", ImmExtE, 32'd4);
    drive(32'h008000EF, 1'b0, 1'b0, 5'd0, 32'h0);   // jal x1,8
    tick();
    check("jal_ctrl", {22'b0, ctrl}, {22'b0, 10'b1_0_1_0_0_10_000});
    check("jal_imm", ImmExtE, 32'd8);
    drive(32'h402081B3, 1'b0, 1'b0, 5'd0, 32'h0);   // sub x3,x1,x2
    tick();
    check("sub_alu", {29'b0, ALUControlE}, 32'd1);
    drive(32'h0010A193, 1'b0, 1'b0, 5'd0, 32'h0);   // slti x3,x1,1
    tick();
    check("slti_alu", {29'b0, ALUControlE}, 32'd5);
    drive(32'hFFF0C193, 1'b0, 1'b0, 5'd0, 32'h0);   // xori x3,x1,-1
    tick();
    check("xori_alu", {29'b0, ALUControlE}, 32'd4);
    check("xori_imm", ImmExtE, 32'hFFFFFFFF);
    drive(32'hC0008193, 1'b0, 1'b0, 5'd0, 32'h0);   // addi x3,x1,-1024 (bit30 set)
    tick();
    check("addi_b30_alu", {29'b0, ALUControlE}, 32'd0);
    check("addi_b30_imm", ImmExtE, 32'hFFFFFC00);
    drive(32'h0020E1B3, 1'b0, 1'b0, 5'd0, 32'h0);   // or x3,x1,x2
    tick();
    check("or_alu", {29'b0, ALUControlE}, 32'd3);
    drive(32'h0020F1B3, 1'b0, 1'b0, 5'd0, 32'h0);   // and x3,x1,x2
    tick();
    check("and_alu", {29'b0, ALUControlE}, 32'd2);
    PCD = 32'h200;
    drive(32'h000000FF, 1'b0, 1'b0, 5'd0, 32'h0);   // unsupported opcode
    tick();
    check("badop_ctrl", {22'b0, ctrl}, 32'h0);
    check("badop_pc", PCE, 32'h200);
    drive(32'h000010B3, 1'b0, 1'b0, 5'd0, 32'h0);   // R-type funct3 001
    tick();
    check("badf3_ctrl", {22'b0, ctrl}, 32'h0);
    check("badf3_rd", {27'b0, RdE}, 32'd1);

    drive(32'h000280B3, 1'b0, 1'b1, 5'd5, 32'd7);   // write x5=7, read x5
    tick();
    check("x5_load", RD1E, 32'd7);
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    drive(32'h000280B3, 1'b0, 1'b1, 5'd5, 32'd9);
    tick();
    rst = 1'b0;
    drive(32'h000280B3, 1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    check("x5_after_rst", RD1E, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Decode stage of the five-stage RV32I pipeline and the consumer of the fetch stage's IF/ID register (InstrD, PCD, PCNextD). It decodes the instruction, reads the 32×32 register file, and sign-extends the immediate. It captures all of this into the ID/EX pipeline register for the execute stage. The same redirect that flushes fetch also turns the ID/EX register into a bubble, and the writeback stage writes the register file through this block.

## Interface
- No parameters; widths fixed at XLEN = 32, 32 architectural registers.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCNextD  in  32  PC+4 of InstrD
- FlushE  in  1  redirect taken (same net as fetch's PC_Sel); bubbles ID/EX on next edge
- RegWriteW  in  1  writeback enable
- RdW  in  5  writeback destination
- ResultW  in  32  writeback data
- Rs1D, Rs2D  out  5 each  combinational source fields, for the hazard unit
- RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE  out  1 each  registered control
- ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
- ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
- Funct3E  out  3  registered funct3 (branch condition: 000 beq, 001 bne)
- RD1E, RD2E, ImmExtE, PCE, PCNextE  out  32 each  registered data
- RdE, Rs1E, Rs2E  out  5 each  registered register indices

## Operation
- Opcode decode:
  - 0110011 R-type: RegWrite, ALUSrc=0.
  - 0010011 I-ALU: RegWrite, ALUSrc=1, I-imm.
  - 0000011 lw: RegWrite, ALUSrc=1, ResultSrc=01, add.
  - 0100011 sw: MemWrite, ALUSrc=1, S-imm, add.
  - 1100011 branch: Branch, sub, B-imm.
  - 1101111 jal: Jump, RegWrite, ResultSrc=10, J-imm.
  - 0110111 lui: RegWrite, ALUSrc=1, U-imm, add with RD1 forced 0.
- ALU decode (R and I-ALU):
  - funct3 000 → add. For R-type only, funct7[5]=1 selects sub; I-type addi ignores funct7.
  - funct3 100 → xor, 110 → or, 111 → and, 010 → slt.
- Unsupported opcode or funct3: all control outputs 0 (bubble). Data fields still captured.
- RegWriteE is forced 0 when rd==0. The fetch flush NOP 0x00000033 therefore produces no write.
- Immediates (Instr = instruction word), all sign-extended from Instr[31]:
  - I = Instr[31:20]
  - S = {Instr[31:25], Instr[11:7]}
  - B = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 0}
  - J = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 0}
  - U = {Instr[31:12], 12'b0}
- Register file:
  - 2 combinational read ports and 1 synchronous write port (posedge, RegWriteW && RdW≠0).
  - x0 always reads 0.
  - Write-through: if RegWriteW, RdW≠0 and RdW equals the read index, the read returns ResultW in that same cycle.
- Flush: FlushE=1 at an edge loads ID/EX with all zeros, control and data. Register file writes still occur.
- FlushE takes priority over capture. Simultaneous flush and writeback: the write lands, the bubble is inserted.

## Timing
- Decode-to-execute latency is 1 cycle: InstrD valid in cycle n → *E outputs valid in cycle n+1.
- Rs1D and Rs2D have zero latency (combinational from InstrD).
- Writeback lands at the edge. A read in the same cycle sees the new value via bypass; later cycles see it from the array.
- Reset, asynchronous and immediate:
  - Every *E output is 0.
  - All 32 registers are 0.
- Reset asserted mid-operation discards the in-flight ID/EX contents and any pending write.
- Release of reset: first edge captures whatever InstrD holds (fetch presents 0 on reset, which decodes as a bubble).

## Structure
- Shared package riscv_pkg:
  - opcode constants
  - ALUControl codes
  - ResultSrc codes
  - immediate-type enum (I/S/B/J/U)
  - XLEN constant
- Sub-module register_file: 32×32 array, async reset, write-through bypass, x0 hardwired.
- Remaining blocks: the control decode and immediate generator are combinational logic inside decode_cycle, followed by the ID/EX register.

## Test plan
- Reset, then InstrD=0x00500093 (addi x1,x0,5) → next cycle: RegWriteE=1, ALUSrcE=1, ImmExtE=5, RdE=1, ALUControlE=000.
- RegWriteW=1, RdW=3, ResultW=0xDEADBEEF while InstrD=0x003100B3 (add x1,x2,x3) → RD2E=0xDEADBEEF on the same edge (bypass).
- InstrD=0xFE000EE3 (beq x0,x0,-4) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFFC.
- InstrD=0x00000033 with FlushE=1 → all *E outputs 0. Separately, with FlushE=0 → RegWriteE=0 (rd=0).
- Write x0 with 0x1234, then read x0 → RD1E=0.
- Assert rst mid-stream after loading x5=7 → all outputs 0 at once. A later read of x5 returns 0.
